// File: rtl/out_fifo_axis_tx.sv
// out_fifo_axis_tx: drains result blocks from the output SRAM
// and streams them out as an AXI-Stream master packet.
module out_fifo_axis_tx #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128,
    parameter int AXIS_WIDTH = 32,
    parameter int DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   blk_count,
    output logic [0:ADDR_WIDTH-1] sram_addr,
    output logic                  sram_r_e,
    input  logic [0:DATA_WIDTH-1] sram_data,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int BEATS = DATA_WIDTH / AXIS_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [BW-1:0]       LAST_B  = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     left_q, left_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [0:DATA_WIDTH-1]   shreg_q, shreg_d;

    logic [ADDR_WIDTH:0]     cnt_sat;
    logic                    last_beat;
    logic                    final_blk;

    assign cnt_sat   = (blk_count > DEPTH_C) ? DEPTH_C : blk_count;
    assign last_beat = (beat_q == LAST_B);
    assign final_blk = (left_q == (ADDR_WIDTH+1)'(1));

    // State, pointers, counters and the output shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            left_q   <= '0;
            beat_q   <= '0;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            left_q   <= left_d;
            beat_q   <= beat_d;
            shreg_q  <= shreg_d;
        end
    end

    // Next-state logic: fetch a block, load it, then shift it out.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        left_d   = left_q;
        beat_d   = beat_q;
        shreg_d  = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    left_d   = cnt_sat;
                    rd_ptr_d = '0;
                    beat_d   = '0;
                    state_d  = (cnt_sat == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = sram_data;
                beat_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (m_axis_tready) begin
                    shreg_d = shreg_q << AXIS_WIDTH;
                    if (last_beat) begin
                        beat_d = '0;
                        left_d = left_q - 1'b1;
                        if (final_blk) begin
                            state_d = DONE;
                        end else begin
                            // Only advance when another block follows,
                            // so the pointer stays below DEPTH.
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            state_d  = FETCH;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only, so tvalid
    // never depends on tready and everything is 0 in reset.
    always_comb begin
        sram_r_e      = (state_q == FETCH);
        sram_addr     = (state_q == FETCH) ? rd_ptr_q : '0;
        m_axis_tvalid = (state_q == SEND);
        m_axis_tdata  = (state_q == SEND) ? shreg_q[0:AXIS_WIDTH-1] : '0;
        m_axis_tlast  = (state_q == SEND) && last_beat && final_blk;
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
    end

endmodule

// File: tb/tb_out_fifo_axis_tx.sv
// tb_out_fifo_axis_tx: directed and randomized packets checked
// against an expected-beat queue built from the SRAM image.
module tb_out_fifo_axis_tx;

    localparam int AW = 9;
    localparam int DW = 128;
    localparam int XW = 32;
    localparam int DP = 512;
    localparam int NB = DW / XW;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW:0]   blk_count;
    logic [AW-1:0] sram_addr;
    logic          sram_r_e;
    logic [DW-1:0] sram_data;
    logic [XW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DP];

    int total = 0;
    int bad   = 0;

    out_fifo_axis_tx #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .AXIS_WIDTH(XW),
        .DEPTH(DP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .blk_count(blk_count),
        .sram_addr(sram_addr),
        .sram_r_e(sram_r_e),
        .sram_data(sram_data),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast(tlast),
        .busy(busy),
        .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Registered-read SRAM model.
    always @(posedge clk) begin
        if (sram_r_e) sram_data <= mem[sram_addr];
    end

    task automatic chk(input string tag,
                       input logic [63:0] o,
                       input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2 == 0);
        return ($urandom % 4) != 0;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, 64'(sram_addr), 0);
        chk({tag, "_re"}, 64'(sram_r_e), 0);
        chk({tag, "_tdata"}, 64'(tdata), 0);
        chk({tag, "_tvalid"}, 64'(tvalid), 0);
        chk({tag, "_tlast"}, 64'(tlast), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
    endtask

    // One packet: expected beats come straight from the SRAM image,
    // leftmost word first, tlast on the very last word.
    task automatic run(input int n, input int rmode, input bit poke);
        int eff, c, idx, rd, first, hs_last, dc, ndone;
        logic [XW-1:0] eq[$];
        bit            el[$];
        eff = (n > DP) ? DP : n;
        for (int b = 0; b < eff; b++) begin
            for (int w = 0; w < NB; w++) begin
                eq.push_back(mem[b][DW-1-XW*w -: XW]);
                el.push_back(b == eff - 1 && w == NB - 1);
            end
        end
        blk_count = n[AW:0];
        start = 1;
        tready = 1;
        tick();
        start = 0;
        c = 1; idx = 0; rd = 0;
        first = -1; hs_last = -1; dc = -1; ndone = 0;
        tready = rdy(rmode, c);
        while (dc < 0 && c < 20 * eff + 50) begin
            chk("busy", 64'(busy), 1);
            if (sram_r_e) begin
                chk("rd_addr", 64'(sram_addr), 64'(rd));
                rd++;
            end
            if (tvalid) begin
                if (first < 0) first = c;
                if (idx < eq.size()) begin
                    chk("tdata", 64'(tdata), 64'(eq[idx]));
                    chk("tlast", 64'(tlast), 64'(el[idx]));
                end else begin
                    chk("extra_beat", 64'(idx), 64'(eq.size()));
                end
                if (tready) begin
                    hs_last = c;
                    idx++;
                end
            end else begin
                chk("tlast_idle", 64'(tlast), 0);
            end
            if (done) begin
                dc = c;
                ndone++;
            end
            start = poke && (c == 5);
            if (poke) blk_count = 5;
            if (dc < 0) begin
                tick();
                c++;
                tready = rdy(rmode, c);
            end
        end
        chk("timeout", 64'(dc >= 0), 1);
        chk("beats", 64'(idx), 64'(eq.size()));
        chk("reads", 64'(rd), 64'(eff));
        chk("done_cyc", 64'(dc), 64'((eff == 0) ? 1 : hs_last + 1));
        if (rmode == 0) chk("done_full", 64'(dc), 64'(6 * eff + 1));
        if (eff > 0) chk("first_beat", 64'(first), 3);
        else chk("no_valid", 64'(first), 64'(-1));
        start = 0;
        tick();
        chk("idle_busy", 64'(busy), 0);
        chk("idle_done", 64'(done), 0);
        chk("done_count", 64'(ndone), 1);
    endtask

    initial begin
        reset_n = 0;
        start = 0;
        blk_count = '0;
        tready = 0;
        sram_data = '0;
        for (int i = 0; i < DP; i++) mem[i] = '0;
        #12;
        check_zero("reset");
        reset_n = 1;
        tick();
        check_zero("post_reset");

        // single block, full speed
        mem[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        run(1, 0, 0);

        // single block with alternating backpressure
        run(1, 1, 0);

        // three blocks of repeated words
        for (int i = 0; i < 3; i++) mem[i] = {4{32'(i + 1)}};
        run(3, 0, 0);

        // zero-length packet
        run(0, 0, 0);

        // random image, saturating count
        for (int i = 0; i < DP; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        run(600, 0, 0);

        // start pulsed mid-transfer is ignored
        run(2, 0, 1);

        // random lengths with random backpressure
        for (int k = 0; k < 6; k++) run($urandom_range(1, 6), 2, 0);

        // reset between beats 2 and 3
        blk_count = 2;
        start = 1;
        tready = 1;
        tick();
        start = 0;
        for (int c = 1; c < 5; c++) tick();
        chk("pre_rst_valid", 64'(tvalid), 1);
        chk("pre_rst_beat3", 64'(tdata), 64'(mem[0][63:32]));
        #2;
        reset_n = 0;
        #1;
        check_zero("async_rst");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_tlast", 64'(tlast), 0);
            chk("rst_done", 64'(done), 0);
        end
        reset_n = 1;
        tick();
        run(2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
